// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central hazard scheduler for the 5-stage core (stall/flush/redirect + perf counters).
// Latency: control outputs are combinational from state and current inputs (same-cycle response).
// Backpressure: an outstanding data access (mem_req without mem_ack) freezes IF/ID/EX until acked.
module pipeline_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int PERF_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  input  logic [REG_W-1:0]  dec_rs1,
  input  logic [REG_W-1:0]  dec_rs2,
  input  logic              dec_rs1_used,
  input  logic              dec_rs2_used,
  input  logic              ex_valid,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_is_load,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_ex,
  output logic              flush_id,
  output logic              flush_ex,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [1:0]        state_o,
  output logic [PERF_W-1:0] stall_count,
  output logic [PERF_W-1:0] flush_count
);

  // The counter only has to hold FLUSH_CYCLES-1 (remaining flush-only cycles after the redirect).
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    FLUSH      = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [PERF_W-1:0]  r_stall_count;
  logic [PERF_W-1:0]  r_flush_count;

  logic w_mem_wait;
  logic w_load_use;
  logic w_stall_if;
  logic w_stall_id;
  logic w_stall_ex;
  logic w_flush_id;
  logic w_flush_ex;
  logic w_redirect;

  assign w_mem_wait = mem_req & ~mem_ack;

  // x0 is hardwired zero, so a load targeting it can never feed a dependent instruction.
  assign w_load_use = ex_valid & ex_is_load & (ex_rd != '0) & dec_valid &
                      ((dec_rs1_used & (dec_rs1 == ex_rd)) |
                       (dec_rs2_used & (dec_rs2 == ex_rd)));

  // Next-state and same-cycle control decode; older instructions (memory, then EX) win.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_stall_if = 1'b0;
    w_stall_id = 1'b0;
    w_stall_ex = 1'b0;
    w_flush_id = 1'b0;
    w_flush_ex = 1'b0;
    w_redirect = 1'b0;
    case (r_state)
      RUN: begin
        if (w_mem_wait) begin
          // EX is frozen, so a branch resolving now is simply re-presented after the ack.
          w_stall_if = 1'b1;
          w_stall_id = 1'b1;
          w_stall_ex = 1'b1;
          w_next     = MEM_WAIT;
        end else if (ex_valid & br_taken) begin
          w_flush_id = 1'b1;
          w_flush_ex = 1'b1;
          w_redirect = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_next     = FLUSH;
            w_cnt_next = CNT_W'(FLUSH_CYCLES - 1);
          end
        end else if (w_load_use) begin
          // Hold IF/ID one cycle and let a bubble enter EX behind the load.
          w_stall_if = 1'b1;
          w_stall_id = 1'b1;
          w_flush_ex = 1'b1;
          w_next     = LOAD_STALL;
        end
      end
      LOAD_STALL: begin
        // The stalled consumer is re-decoded against the bubble, so no hazard check here.
        if (w_mem_wait) begin
          w_stall_if = 1'b1;
          w_stall_id = 1'b1;
          w_stall_ex = 1'b1;
          w_next     = MEM_WAIT;
        end else begin
          w_next = RUN;
        end
      end
      MEM_WAIT: begin
        if (!mem_ack) begin
          w_stall_if = 1'b1;
          w_stall_id = 1'b1;
          w_stall_ex = 1'b1;
        end else begin
          w_next = RUN;
        end
      end
      FLUSH: begin
        w_flush_id = 1'b1;
        if (w_mem_wait) begin
          // Wrong-path decode must stay squashed while frozen; the countdown pauses.
          w_stall_if = 1'b1;
          w_stall_id = 1'b1;
          w_stall_ex = 1'b1;
        end else if (r_cnt <= CNT_W'(1)) begin
          w_cnt_next = '0;
          w_next     = RUN;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_next     = RUN;
        w_cnt_next = '0;
      end
    endcase
  end

  // State and flush countdown; reset returns to RUN from any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Saturating perf counters: stall cycles and taken-branch redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_stall_if && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + PERF_W'(1);
      end
      if (w_redirect && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + PERF_W'(1);
      end
    end
  end

  // Controls are forced low during reset so nothing downstream moves in that cycle.
  assign stall_if       = w_stall_if & ~reset;
  assign stall_id       = w_stall_id & ~reset;
  assign stall_ex       = w_stall_ex & ~reset;
  assign flush_id       = w_flush_id & ~reset;
  assign flush_ex       = w_flush_ex & ~reset;
  assign redirect_valid = w_redirect & ~reset;
  assign redirect_pc    = br_target;
  assign state_o        = r_state;
  assign stall_count    = r_stall_count;
  assign flush_count    = r_flush_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: drives two pipeline_ctrl instances (default, and short counters / longer flush)
// with directed hazard scenarios then random traffic, comparing against a behavioural model.
// Model tracks "waiting on memory", "bubble just inserted" and "flush cycles left" as plain flags.
module tb_pipeline_ctrl;
  localparam int AW = 32;
  localparam int RW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, dec_valid, dec_rs1_used, dec_rs2_used;
  logic          ex_valid, ex_is_load, br_taken, mem_req, mem_ack;
  logic [RW-1:0] dec_rs1, dec_rs2, ex_rd;
  logic [AW-1:0] br_target;

  logic          a_sif, a_sid, a_sex, a_fid, a_fex, a_rv;
  logic [AW-1:0] a_pc;
  logic [1:0]    a_state;
  logic [15:0]   a_scnt, a_fcnt;
  logic          b_sif, b_sid, b_sex, b_fid, b_fex, b_rv;
  logic [AW-1:0] b_pc;
  logic [1:0]    b_state;
  logic [2:0]    b_scnt, b_fcnt;

  pipeline_ctrl #(.ADDR_W(AW), .REG_W(RW), .FLUSH_CYCLES(2), .PERF_W(16)) dut_a (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .br_taken(br_taken), .br_target(br_target),
    .mem_req(mem_req), .mem_ack(mem_ack), .stall_if(a_sif), .stall_id(a_sid),
    .stall_ex(a_sex), .flush_id(a_fid), .flush_ex(a_fex), .redirect_valid(a_rv),
    .redirect_pc(a_pc), .state_o(a_state), .stall_count(a_scnt), .flush_count(a_fcnt));

  pipeline_ctrl #(.ADDR_W(AW), .REG_W(RW), .FLUSH_CYCLES(3), .PERF_W(3)) dut_b (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .br_taken(br_taken), .br_target(br_target),
    .mem_req(mem_req), .mem_ack(mem_ack), .stall_if(b_sif), .stall_id(b_sid),
    .stall_ex(b_sex), .flush_id(b_fid), .flush_ex(b_fex), .redirect_valid(b_rv),
    .redirect_pc(b_pc), .state_o(b_state), .stall_count(b_scnt), .flush_count(b_fcnt));

  wire [5:0] a_ctl = {a_sif, a_sid, a_sex, a_fid, a_fex, a_rv};
  wire [5:0] b_ctl = {b_sif, b_sid, b_sex, b_fid, b_fex, b_rv};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model, one slot per instance.
  int FC[2]   = '{2, 3};
  int CMAX[2] = '{65535, 7};
  bit m_wait[2];
  bit m_bubble[2];
  int m_fleft[2];
  int m_scnt[2];
  int m_fcnt[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_state(input int k);
    if (m_wait[k])        return 2;
    if (m_fleft[k] > 0)   return 3;
    if (m_bubble[k])      return 1;
    return 0;
  endfunction

  // Applies the scheduling rules to the current inputs; returns this cycle's controls and
  // advances the model to what it should be after the clock edge.
  task automatic model_step(input int k, output logic [5:0] ctl);
    bit mw, frz, sif, sid, fid, fex, rv, lu, was_bubble;
    mw  = mem_req && !mem_ack;
    frz = 0; sif = 0; sid = 0; fid = 0; fex = 0; rv = 0;
    lu  = ex_valid && ex_is_load && (ex_rd != 0) && dec_valid &&
          ((dec_rs1_used && dec_rs1 == ex_rd) || (dec_rs2_used && dec_rs2 == ex_rd));
    if (reset) begin
      m_wait[k] = 0; m_bubble[k] = 0; m_fleft[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
    end else begin
      if (m_wait[k]) begin
        if (!mem_ack) frz = 1;
        else m_wait[k] = 0;
      end else if (m_fleft[k] > 0) begin
        fid = 1;
        if (mw) frz = 1;
        else m_fleft[k]--;
      end else begin
        was_bubble  = m_bubble[k];
        m_bubble[k] = 0;
        if (mw) begin
          frz = 1; m_wait[k] = 1;
        end else if (!was_bubble) begin
          if (ex_valid && br_taken) begin
            fid = 1; fex = 1; rv = 1;
            if (m_fcnt[k] < CMAX[k]) m_fcnt[k]++;
            m_fleft[k] = FC[k] - 1;
          end else if (lu) begin
            sif = 1; sid = 1; fex = 1; m_bubble[k] = 1;
          end
        end
      end
      if ((frz || sif) && m_scnt[k] < CMAX[k]) m_scnt[k]++;
    end
    ctl = {frz | sif, frz | sid, frz, fid, fex, rv};
  endtask

  // One clock: compare combinational outputs mid-cycle, then registered state after the edge.
  task automatic tick();
    logic [5:0] e_ctl;
    @(negedge clk);
    model_step(0, e_ctl);
    check("ctl_a", a_ctl, e_ctl);
    model_step(1, e_ctl);
    check("ctl_b", b_ctl, e_ctl);
    check("pc_a", a_pc, br_target);
    check("pc_b", b_pc, br_target);
    @(posedge clk);
    #1;
    check("state_a", a_state, exp_state(0));
    check("state_b", b_state, exp_state(1));
    check("scnt_a", a_scnt, m_scnt[0]);
    check("scnt_b", b_scnt, m_scnt[1]);
    check("fcnt_a", a_fcnt, m_fcnt[0]);
    check("fcnt_b", b_fcnt, m_fcnt[1]);
  endtask

  task automatic idle();
    reset = 0; dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rs1_used = 0; dec_rs2_used = 0;
    ex_valid = 0; ex_rd = 0; ex_is_load = 0; br_taken = 0; br_target = 0;
    mem_req = 0; mem_ack = 0;
  endtask

  task automatic set_load_use(input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                              input logic [RW-1:0] rs2, input logic u1, input logic u2,
                              input logic is_load);
    ex_valid = 1; ex_is_load = is_load; ex_rd = rd;
    dec_valid = 1; dec_rs1 = rs1; dec_rs2 = rs2; dec_rs1_used = u1; dec_rs2_used = u2;
  endtask

  initial begin
    idle();
    // Reset held with branch and memory wait pending: everything stays quiet.
    reset = 1; br_taken = 1; ex_valid = 1; mem_req = 1;
    repeat (3) tick();
    check("t1_state", a_state, 2'd0);
    check("t1_scnt", a_scnt, 16'd0);

    // Load-use on rs2: one stall cycle with a bubble.
    idle();
    set_load_use(5'd5, 5'd1, 5'd5, 1'b0, 1'b1, 1'b1);
    tick();
    idle();
    repeat (2) tick();
    check("t2_scnt", a_scnt, 16'd1);

    // Loads to x0 and non-load producers never stall.
    set_load_use(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    tick();
    set_load_use(5'd5, 5'd5, 5'd3, 1'b1, 1'b1, 1'b0);
    tick();
    check("t3_scnt", a_scnt, 16'd1);

    // Taken branch: redirect to 0x100, flush_id spans FLUSH_CYCLES.
    idle();
    ex_valid = 1; br_taken = 1; br_target = 32'h100;
    tick();
    idle();
    repeat (3) tick();
    check("t4_fcnt", a_fcnt, 16'd1);

    // Memory wait with a same-cycle branch: 4 stall cycles, no redirect until re-presented.
    idle();
    mem_req = 1; ex_valid = 1; br_taken = 1; br_target = 32'h200;
    repeat (4) tick();
    mem_ack = 1;
    tick();
    check("t5_scnt", a_scnt, 16'd5);
    mem_req = 0; mem_ack = 0;
    tick();
    check("t5_fcnt", a_fcnt, 16'd2);
    idle();
    repeat (3) tick();

    // Saturation of the narrow counter, then reset in the middle of a memory wait.
    mem_req = 1;
    repeat (5) tick();
    check("t6_sat", b_scnt, 3'd7);
    reset = 1;
    tick();
    check("t6_state", a_state, 2'd0);
    idle();
    tick();

    // Random traffic with small register indices so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 199) == 0);
      dec_valid    = $urandom_range(0, 3) != 0;
      dec_rs1      = RW'($urandom_range(0, 3));
      dec_rs2      = RW'($urandom_range(0, 3));
      dec_rs1_used = $urandom_range(0, 1);
      dec_rs2_used = $urandom_range(0, 1);
      ex_valid     = $urandom_range(0, 3) != 0;
      ex_rd        = RW'($urandom_range(0, 3));
      ex_is_load   = $urandom_range(0, 1);
      br_taken     = $urandom_range(0, 5) == 0;
      br_target    = $urandom;
      mem_req      = $urandom_range(0, 5) == 0;
      mem_ack      = $urandom_range(0, 2) == 0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
